el2_ccm_bank_ctrl: RTL and testbench

//  Parametrised multi-port, multi-bank front-end for closely-coupled memories (DCCM/ICCM class).

---
 rtl/el2_ccm_bank_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_el2_ccm_bank_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/el2_ccm_bank_ctrl.sv
// Multi-port, multi-bank CCM front end: per-bank round-robin arbitration onto
// word-interleaved SRAM banks, fixed-latency read return and ECC fix write-back.

module el2_ccm_bank_arb #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_BITS-1:0] win
);
  logic [PORT_BITS-1:0] ptr;
  logic [PORT_BITS-1:0] sel;
  logic                 found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sel = PORT_BITS'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        win      = sel;
      end
    end
  end

  // A lone requester never rotates priority; only real contention does.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if ($countones(req) >= 2)
      ptr <= (win == PORT_BITS'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
  end
endmodule

module el2_ccm_rd_pipe #(
  parameter int RD_LAT    = 1,
  parameter int BANK_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  input  logic [BANK_BITS-1:0] bank_in,
  output logic                 valid,
  output logic [BANK_BITS-1:0] bank_out
);
  logic [RD_LAT:1]                vld_pipe;
  logic [RD_LAT:1][BANK_BITS-1:0] bank_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      bank_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      bank_pipe[1] <= bank_in;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        bank_pipe[i] <= bank_pipe[i-1];
      end
    end
  end

  assign valid    = vld_pipe[RD_LAT];
  assign bank_out = bank_pipe[RD_LAT];
endmodule

module el2_ccm_bank_ctrl #(
  parameter int  NUM_PORTS  = 2,
  parameter int  NUM_BANKS  = 4,
  parameter int  ADDR_BITS  = 16,
  parameter int  DATA_WIDTH = 39,
  parameter int  RD_LAT     = 1,
  localparam int BANK_BITS  = $clog2(NUM_BANKS),
  localparam int ROW_BITS   = ADDR_BITS - 2 - BANK_BITS,
  localparam int PORT_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  output logic [NUM_PORTS-1:0]                  req_ready,
  input  logic [NUM_PORTS-1:0]                  req_we,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  rsp_valid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rsp_rdata,
  output logic [NUM_BANKS-1:0]                  bank_clken,
  output logic [NUM_BANKS-1:0]                  bank_wren,
  output logic [NUM_BANKS-1:0][ROW_BITS-1:0]    bank_addr,
  output logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_wdata,
  input  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_dout,
  input  logic                                  fix_req,
  input  logic [ADDR_BITS-1:0]                  fix_addr,
  input  logic [DATA_WIDTH-1:0]                 fix_data,
  output logic                                  fix_busy
);
  typedef enum logic {IDLE, FIX} fix_state_e;

  fix_state_e                              state, state_nxt;
  logic [BANK_BITS-1:0]                    fix_bank_q;
  logic [ROW_BITS-1:0]                     fix_row_q;
  logic [DATA_WIDTH-1:0]                   fix_data_q;
  logic                                    active;

  logic [NUM_PORTS-1:0][BANK_BITS-1:0]     port_bank;
  logic [NUM_PORTS-1:0][ROW_BITS-1:0]      port_row;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]     bank_req;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]     bank_gnt;
  logic [NUM_BANKS-1:0][PORT_BITS-1:0]     bank_win;
  logic [NUM_PORTS-1:0]                    pipe_vld;
  logic [NUM_PORTS-1:0][BANK_BITS-1:0]     pipe_bank;
  logic                                    unused_fix_lsbs;

  // Ports only compete for banks while no correction write-back owns the array.
  assign active   = ~rst & (state == IDLE);
  assign fix_busy = ~rst & (state == FIX);
  assign unused_fix_lsbs = ^fix_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fix_bank_q <= '0;
      fix_row_q  <= '0;
      fix_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && fix_req) begin
        fix_bank_q <= fix_addr[2 +: BANK_BITS];
        fix_row_q  <= fix_addr[ADDR_BITS-1:2+BANK_BITS];
        fix_data_q <= fix_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fix_req) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic unused_lsbs;
    assign unused_lsbs  = ^req_addr[p][1:0];
    assign port_bank[p] = req_addr[p][2 +: BANK_BITS];
    assign port_row[p]  = req_addr[p][ADDR_BITS-1:2+BANK_BITS];

    el2_ccm_rd_pipe #(
      .RD_LAT    (RD_LAT),
      .BANK_BITS (BANK_BITS)
    ) u_rd_pipe (
      .clk      (clk),
      .rst      (rst),
      .issue    (req_ready[p] & ~req_we[p]),
      .bank_in  (port_bank[p]),
      .valid    (pipe_vld[p]),
      .bank_out (pipe_bank[p])
    );

    assign rsp_valid[p] = pipe_vld[p] & ~rst;
    assign rsp_rdata[p] = rsp_valid[p] ? bank_dout[pipe_bank[p]] : '0;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
      assign bank_req[b][p] = active & req_valid[p] & (port_bank[p] == BANK_BITS'(b));
    end

    el2_ccm_bank_arb #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_BITS (PORT_BITS)
    ) u_arb (
      .clk (clk),
      .rst (rst),
      .req (bank_req[b]),
      .gnt (bank_gnt[b]),
      .win (bank_win[b])
    );
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      req_ready = req_ready | bank_gnt[b];
  end

  // Bank pins are driven straight from the arbiter so the SRAM sees the access in the grant cycle.
  always_comb begin
    bank_clken = '0;
    bank_wren  = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (fix_busy && fix_bank_q == BANK_BITS'(b)) begin
        bank_clken[b] = 1'b1;
        bank_wren[b]  = 1'b1;
        bank_addr[b]  = fix_row_q;
        bank_wdata[b] = fix_data_q;
      end else if (|bank_gnt[b]) begin
        bank_clken[b] = 1'b1;
        bank_wren[b]  = req_we[bank_win[b]];
        bank_addr[b]  = port_row[bank_win[b]];
        bank_wdata[b] = req_wdata[bank_win[b]];
      end
    end
  end
endmodule

// File: tb/tb_el2_ccm_bank_ctrl.sv
// Directed bench for el2_ccm_bank_ctrl: RD_LAT=1 instance with an SRAM model,
// plus an RD_LAT=2 instance sharing the requests for the mid-operation reset case.

module tb_el2_ccm_bank_ctrl;
  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][15:0]  req_addr;
  logic [1:0][38:0]  req_wdata, rsp_rdata;
  logic [3:0]        bank_clken, bank_wren;
  logic [3:0][11:0]  bank_addr;
  logic [3:0][38:0]  bank_wdata, bank_dout;
  logic              fix_req, fix_busy;
  logic [15:0]       fix_addr;
  logic [38:0]       fix_data;

  logic [1:0]        r2_req_ready, r2_rsp_valid;
  logic [1:0][38:0]  r2_rsp_rdata;
  logic [3:0]        r2_bank_clken, r2_bank_wren;
  logic [3:0][11:0]  r2_bank_addr;
  logic [3:0][38:0]  r2_bank_wdata, r2_bank_dout;
  logic              r2_fix_busy;

  logic [38:0]       mem [4][4096];
  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  assign r2_bank_dout = {39'h103, 39'h102, 39'h101, 39'h100};

  el2_ccm_bank_ctrl #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_clken(bank_clken), .bank_wren(bank_wren), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_dout(bank_dout), .fix_req(fix_req), .fix_addr(fix_addr),
    .fix_data(fix_data), .fix_busy(fix_busy)
  );

  el2_ccm_bank_ctrl #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r2_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rsp_rdata),
    .bank_clken(r2_bank_clken), .bank_wren(r2_bank_wren), .bank_addr(r2_bank_addr),
    .bank_wdata(r2_bank_wdata), .bank_dout(r2_bank_dout), .fix_req(fix_req), .fix_addr(fix_addr),
    .fix_data(fix_data), .fix_busy(r2_fix_busy)
  );

  // SRAM model: word at bank b, row r powers up as {7'(64+b), 32'(r)}.
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++)
        for (int r = 0; r < 4096; r++)
          mem[b][r] <= {7'(64 + b), 32'(r)};
      bank_dout <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bank_clken[b]) begin
          if (bank_wren[b]) mem[b][bank_addr[b]] <= bank_wdata[b];
          else              bank_dout[b] <= mem[b][bank_addr[b]];
        end
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task test_reset;
    rst = 1'b1; req_valid = 2'b11; req_we = 2'b00; fix_req = 1'b0;
    req_addr[0] = 16'h0004; req_addr[1] = 16'h0008;
    req_wdata[0] = 39'h1; req_wdata[1] = 39'h2; fix_addr = 16'h0; fix_data = 39'h0;
    tick; tick; #3;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready got %b want 00", req_ready); end
    tests++; if (bank_clken !== 4'b0) begin fails++; $display("FAIL reset_clken got %b want 0000", bank_clken); end
    tests++; if (bank_wren !== 4'b0) begin fails++; $display("FAIL reset_wren got %b want 0000", bank_wren); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    tests++; if (fix_busy !== 1'b0) begin fails++; $display("FAIL reset_fix_busy got %b want 0", fix_busy); end
    tests++; if (bank_addr !== '0 || bank_wdata !== '0 || rsp_rdata !== '0) begin
      fails++; $display("FAIL reset_data got addr %h wdata %h rdata %h want 0", bank_addr, bank_wdata, rsp_rdata); end
    tests++; if (r2_rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_r2_rsp got %b want 00", r2_rsp_valid); end
    rst = 1'b0; req_valid = 2'b00;
  endtask

  task test_parallel;
    tick;
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 16'h0004; req_addr[1] = 16'h0008;
    #3;
    tests++; if (req_ready !== 2'b11) begin fails++; $display("FAIL par_ready got %b want 11", req_ready); end
    tests++; if (bank_clken !== 4'b0110) begin fails++; $display("FAIL par_clken got %b want 0110", bank_clken); end
    tests++; if (bank_wren !== 4'b0000) begin fails++; $display("FAIL par_wren got %b want 0000", bank_wren); end
    tick;
    req_valid = 2'b00;
    #3;
    tests++; if (rsp_valid !== 2'b11) begin fails++; $display("FAIL par_rsp_valid got %b want 11", rsp_valid); end
    tests++; if (rsp_rdata[0] !== 39'h4100000000) begin fails++; $display("FAIL par_rdata0 got %h want 4100000000", rsp_rdata[0]); end
    tests++; if (rsp_rdata[1] !== 39'h4200000000) begin fails++; $display("FAIL par_rdata1 got %h want 4200000000", rsp_rdata[1]); end
  endtask

  task test_conflict;
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    tick;
    req_valid = 2'b11; req_we = 2'b00; req_addr[0] = 16'h0000; req_addr[1] = 16'h0010;
    for (int k = 0; k < 4; k++) begin
      #3;
      tests++; if (req_ready !== exp_g[k]) begin fails++; $display("FAIL conf_grant%0d got %b want %b", k, req_ready, exp_g[k]); end
      tests++; if (bank_clken !== 4'b0001) begin fails++; $display("FAIL conf_clken%0d got %b want 0001", k, bank_clken); end
      if (k > 0) begin
        tests++; if (rsp_valid !== exp_g[k-1]) begin fails++; $display("FAIL conf_rsp%0d got %b want %b", k, rsp_valid, exp_g[k-1]); end
        tests++;
        if (exp_g[k-1] == 2'b01 ? rsp_rdata[0] !== 39'h4000000000 : rsp_rdata[1] !== 39'h4000000001) begin
          fails++; $display("FAIL conf_rdata%0d got %h/%h", k, rsp_rdata[0], rsp_rdata[1]); end
      end
      tick;
    end
    req_valid = 2'b00;
    #3;
    tests++; if (rsp_valid !== 2'b10) begin fails++; $display("FAIL conf_rsp_last got %b want 10", rsp_valid); end
    tests++; if (rsp_rdata[1] !== 39'h4000000001) begin fails++; $display("FAIL conf_rdata_last got %h want 4000000001", rsp_rdata[1]); end
  endtask

  task test_raw;
    tick;
    req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 16'h0010; req_wdata[0] = 39'h12345678A;
    #3;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL raw_wr_ready got %b want 01", req_ready); end
    tests++; if (bank_wren !== 4'b0001) begin fails++; $display("FAIL raw_wren got %b want 0001", bank_wren); end
    tests++; if (bank_addr[0] !== 12'd1) begin fails++; $display("FAIL raw_row got %h want 1", bank_addr[0]); end
    tests++; if (bank_wdata[0] !== 39'h12345678A) begin fails++; $display("FAIL raw_wdata got %h want 12345678a", bank_wdata[0]); end
    tick;
    req_we = 2'b00;
    #3;
    tests++; if (req_ready !== 2'b01 || bank_wren !== 4'b0) begin fails++; $display("FAIL raw_rd_grant got %b/%b want 01/0000", req_ready, bank_wren); end
    tick;
    req_valid = 2'b00;
    #3;
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL raw_rsp_valid got %b want 01", rsp_valid); end
    tests++; if (rsp_rdata[0] !== 39'h12345678A) begin fails++; $display("FAIL raw_rdata got %h want 12345678a", rsp_rdata[0]); end
  endtask

  task test_fix;
    tick;
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 16'h0004;
    fix_req = 1'b1; fix_addr = 16'h0020; fix_data = 39'h7A5A5A5A5A;
    #3;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL fix_same_cycle_ready got %b want 01", req_ready); end
    tests++; if (fix_busy !== 1'b0) begin fails++; $display("FAIL fix_busy_early got %b want 0", fix_busy); end
    tick;
    fix_addr = 16'h0024; fix_data = 39'h0123456789;
    #3;
    tests++; if (fix_busy !== 1'b1) begin fails++; $display("FAIL fix_busy got %b want 1", fix_busy); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL fix_ready got %b want 00", req_ready); end
    tests++; if (bank_clken !== 4'b0001 || bank_wren !== 4'b0001) begin
      fails++; $display("FAIL fix_bank got clken %b wren %b want 0001/0001", bank_clken, bank_wren); end
    tests++; if (bank_addr[0] !== 12'd2) begin fails++; $display("FAIL fix_row got %h want 2", bank_addr[0]); end
    tests++; if (bank_wdata[0] !== 39'h7A5A5A5A5A) begin fails++; $display("FAIL fix_wdata got %h want 7a5a5a5a5a", bank_wdata[0]); end
    tests++; if (rsp_valid !== 2'b01 || rsp_rdata[0] !== 39'h4100000000) begin
      fails++; $display("FAIL fix_inflight got %b %h want 01 4100000000", rsp_valid, rsp_rdata[0]); end
    tick;
    fix_req = 1'b0;
    #3;
    tests++; if (fix_busy !== 1'b0) begin fails++; $display("FAIL fix_ignored got busy %b want 0", fix_busy); end
    tests++; if (req_ready !== 2'b01 || rsp_valid !== 2'b00) begin
      fails++; $display("FAIL fix_resume got ready %b rsp %b want 01/00", req_ready, rsp_valid); end
    tick;
    req_valid = 2'b10; req_addr[1] = 16'h0020;
    #3;
    tests++; if (req_ready !== 2'b10 || rsp_valid !== 2'b01) begin
      fails++; $display("FAIL fix_readback_grant got ready %b rsp %b want 10/01", req_ready, rsp_valid); end
    tick;
    req_valid = 2'b00;
    #3;
    tests++; if (rsp_valid !== 2'b10 || rsp_rdata[1] !== 39'h7A5A5A5A5A) begin
      fails++; $display("FAIL fix_readback got %b %h want 10 7a5a5a5a5a", rsp_valid, rsp_rdata[1]); end
  endtask

  task test_midreset;
    tick;
    req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 16'h0004;
    #3;
    tests++; if (r2_req_ready !== 2'b01) begin fails++; $display("FAIL mrst_grant got %b want 01", r2_req_ready); end
    tick;
    req_valid = 2'b00; rst = 1'b1;
    #3;
    tests++; if (r2_rsp_valid !== 2'b00) begin fails++; $display("FAIL mrst_rsp_in_reset got %b want 00", r2_rsp_valid); end
    tick;
    rst = 1'b0;
    #3;
    tests++; if (r2_rsp_valid !== 2'b00) begin fails++; $display("FAIL mrst_rsp_dropped got %b want 00", r2_rsp_valid); end
    tests++; if (r2_fix_busy !== 1'b0) begin fails++; $display("FAIL mrst_fsm got busy %b want 0", r2_fix_busy); end
    tick;
    #3;
    tests++; if (r2_rsp_valid !== 2'b00) begin fails++; $display("FAIL mrst_rsp_late got %b want 00", r2_rsp_valid); end
    tick;
    req_valid = 2'b01;
    #3;
    tests++; if (r2_req_ready !== 2'b01 || r2_bank_clken !== 4'b0010) begin
      fails++; $display("FAIL mrst_regrant got %b/%b want 01/0010", r2_req_ready, r2_bank_clken); end
    tick;
    req_valid = 2'b00;
    #3;
    tests++; if (r2_rsp_valid !== 2'b00) begin fails++; $display("FAIL mrst_lat2_early got %b want 00", r2_rsp_valid); end
    tick;
    #3;
    tests++; if (r2_rsp_valid !== 2'b01 || r2_rsp_rdata[0] !== 39'h101) begin
      fails++; $display("FAIL mrst_lat2_rsp got %b %h want 01 101", r2_rsp_valid, r2_rsp_rdata[0]); end
  endtask

  initial begin
    test_reset;
    test_parallel;
    test_conflict;
    test_raw;
    test_fix;
    test_midreset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d tests", tests);
    $fatal(1, "watchdog");
  end
endmodule
